// File: rtl/frame_render_sequencer_pkg.sv
// Shared DinoGame constants and types used by the frame render sequencer.
// The UBYTE_W macro sets the coordinate/object byte width (8 by default).
`ifndef UBYTE_W
`define UBYTE_W 8
`endif

package frame_render_sequencer_pkg;

    localparam int DINO_SCREEN_W = 160;
    localparam int DINO_SCREEN_H = 120;
    localparam int UBYTE_BITS    = `UBYTE_W;

    typedef logic [UBYTE_BITS-1:0] ubyte_t;
    typedef logic [2:0]            color_t;

    typedef enum logic [3:0] {
        GS_TITLE = 4'd0,
        GS_RUN   = 4'd1,
        GS_HIT   = 4'd2,
        GS_OVER  = 4'd3
    } game_state_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SNAP,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } seq_state_e;

    // Coordinate tag that rides alongside the renderer's internal latency.
    typedef struct packed {
        logic   vld;
        ubyte_t x;
        ubyte_t y;
    } tag_t;

    function automatic ubyte_t last_idx(input int n);
        return ubyte_t'(n - 1);
    endfunction

endpackage

// File: rtl/frame_render_sequencer_tag_pipe.sv
// render_tag_pipe: DEPTH-deep {valid, x, y} shift register that mirrors the
// renderer latency; the whole pipe holds when i_freeze is high.
module render_tag_pipe
    import frame_render_sequencer_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_freeze,
    input  tag_t i_tag,
    output tag_t o_tag,
    output logic o_empty
);

    tag_t r_pipe [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
        end else if (!i_freeze) begin
            r_pipe[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_tag = r_pipe[DEPTH-1];

    always_comb begin
        o_empty = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_pipe[i].vld) o_empty = 1'b0;
        end
    end

endmodule

// File: rtl/frame_render_sequencer.sv
// Per-frame scan sequencer: snapshots game state on frame_tick, walks every
// pixel through the renderer and streams colors to the VGA framebuffer.
// Define FRAME_OVERRUN_CNT_EN to add the overrun_cnt lost-tick counter.
module frame_render_sequencer
    import frame_render_sequencer_pkg::*;
#(
    parameter int SCREEN_W   = DINO_SCREEN_W,
    parameter int SCREEN_H   = DINO_SCREEN_H,
    parameter int RENDER_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic [3:0]  game_state,
    input  logic [7:0]  dino_y,
    input  logic [7:0]  obs1_x,
    input  logic [7:0]  obs1_h,
    input  logic [7:0]  obs2_x,
    input  logic [7:0]  obs2_h,
    output logic [7:0]  r_x,
    output logic [7:0]  r_y,
    output logic        r_ld,
    output logic [3:0]  r_game_state,
    output logic [7:0]  r_dino_y,
    output logic [7:0]  r_obs1_x,
    output logic [7:0]  r_obs1_h,
    output logic [7:0]  r_obs2_x,
    output logic [7:0]  r_obs2_h,
    input  logic [2:0]  r_color,
    output logic [7:0]  vga_x,
    output logic [7:0]  vga_y,
    output logic [2:0]  vga_color,
    output logic        vga_plot,
    input  logic        vga_ready,
    output logic        busy,
`ifdef FRAME_OVERRUN_CNT_EN
    output logic [15:0] overrun_cnt,
`endif
    output logic        frame_done
);

    localparam ubyte_t LAST_X = last_idx(SCREEN_W);
    localparam ubyte_t LAST_Y = last_idx(SCREEN_H);

    seq_state_e r_state, w_next;
    ubyte_t     r_xcnt, r_ycnt;
    logic       r_pend;
    logic       w_stall, w_issue, w_last_x, w_last_y, w_pipe_empty;
    tag_t       w_tag_in, w_tag_out;

    assign w_stall  = vga_plot && !vga_ready;
    assign w_issue  = (r_state == S_SCAN) && !w_stall;
    assign w_last_x = (r_xcnt == LAST_X);
    assign w_last_y = (r_ycnt == LAST_Y);
    assign w_tag_in = {w_issue, r_xcnt, r_ycnt};
    assign r_x      = r_xcnt;
    assign r_y      = r_ycnt;

    render_tag_pipe #(.DEPTH(RENDER_LAT)) u_tag_pipe (
        .clk      (clk),
        .reset    (reset),
        .i_freeze (w_stall),
        .i_tag    (w_tag_in),
        .o_tag    (w_tag_out),
        .o_empty  (w_pipe_empty)
    );

    always_comb begin
        w_next     = r_state;
        r_ld       = w_issue;
        busy       = (r_state != S_IDLE);
        frame_done = (r_state == S_DONE);
        unique case (r_state)
            S_IDLE:  if (frame_tick) w_next = S_SNAP;
            S_SNAP:  w_next = S_SCAN;
            S_SCAN:  if (w_issue && w_last_x && w_last_y) w_next = S_DRAIN;
            // Leave once nothing is in flight and the held pixel goes this cycle.
            S_DRAIN: if (w_pipe_empty && (!vga_plot || vga_ready)) w_next = S_DONE;
            S_DONE:  w_next = (r_pend || frame_tick) ? S_SNAP : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pend  <= 1'b0;
            r_xcnt  <= '0;
            r_ycnt  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DONE)
                r_pend <= 1'b0;
            else if (frame_tick && r_state != S_IDLE)
                r_pend <= 1'b1;
            if (r_state == S_SNAP) begin
                r_xcnt <= '0;
                r_ycnt <= '0;
            end else if (w_issue) begin
                if (w_last_x) begin
                    r_xcnt <= '0;
                    r_ycnt <= w_last_y ? '0 : r_ycnt + 8'd1;
                end else begin
                    r_xcnt <= r_xcnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_game_state <= '0;
            r_dino_y     <= '0;
            r_obs1_x     <= '0;
            r_obs1_h     <= '0;
            r_obs2_x     <= '0;
            r_obs2_h     <= '0;
        end else if (r_state == S_SNAP) begin
            r_game_state <= game_state;
            r_dino_y     <= dino_y;
            r_obs1_x     <= obs1_x;
            r_obs1_h     <= obs1_h;
            r_obs2_x     <= obs2_x;
            r_obs2_h     <= obs2_h;
        end
    end

    // The tag emerges in the same cycle the renderer presents that pixel's color.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_plot  <= 1'b0;
            vga_x     <= '0;
            vga_y     <= '0;
            vga_color <= '0;
        end else if (!w_stall) begin
            vga_plot  <= w_tag_out.vld;
            vga_x     <= w_tag_out.x;
            vga_y     <= w_tag_out.y;
            vga_color <= r_color;
        end
    end

`ifdef FRAME_OVERRUN_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            overrun_cnt <= '0;
        else if (frame_tick && r_pend && overrun_cnt != 16'hFFFF)
            overrun_cnt <= overrun_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_frame_render_sequencer.sv
// Directed bench: two sequencers (RENDER_LAT 1 and 3) share stimulus; a pixel
// scoreboard checks every plot, a frame table checks timing and snapshots.
module tb_frame_render_sequencer;

    localparam int NPIX = 160 * 120;
    localparam int LIM  = 25000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       vga_ready = 1'b1;
    logic [3:0] game_state = '0;
    logic [7:0] dino_y = '0, obs1_x = '0, obs1_h = '0, obs2_x = '0, obs2_h = '0;

    logic [7:0] rx [2], ry [2], vx [2], vy [2];
    logic [7:0] sdy [2], so1x [2], so1h [2], so2x [2], so2h [2];
    logic [3:0] sgs [2];
    logic [2:0] vc [2], rcol [2];
    logic       rld [2], vplot [2], busy [2], fdone [2];
`ifdef FRAME_OVERRUN_CNT_EN
    logic [15:0] ovr [2];
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    frame_render_sequencer #(.RENDER_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .game_state(game_state),
        .dino_y(dino_y), .obs1_x(obs1_x), .obs1_h(obs1_h), .obs2_x(obs2_x), .obs2_h(obs2_h),
        .r_x(rx[0]), .r_y(ry[0]), .r_ld(rld[0]), .r_game_state(sgs[0]),
        .r_dino_y(sdy[0]), .r_obs1_x(so1x[0]), .r_obs1_h(so1h[0]),
        .r_obs2_x(so2x[0]), .r_obs2_h(so2h[0]), .r_color(rcol[0]),
        .vga_x(vx[0]), .vga_y(vy[0]), .vga_color(vc[0]), .vga_plot(vplot[0]),
        .vga_ready(vga_ready), .busy(busy[0]),
`ifdef FRAME_OVERRUN_CNT_EN
        .overrun_cnt(ovr[0]),
`endif
        .frame_done(fdone[0])
    );

    frame_render_sequencer #(.RENDER_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .game_state(game_state),
        .dino_y(dino_y), .obs1_x(obs1_x), .obs1_h(obs1_h), .obs2_x(obs2_x), .obs2_h(obs2_h),
        .r_x(rx[1]), .r_y(ry[1]), .r_ld(rld[1]), .r_game_state(sgs[1]),
        .r_dino_y(sdy[1]), .r_obs1_x(so1x[1]), .r_obs1_h(so1h[1]),
        .r_obs2_x(so2x[1]), .r_obs2_h(so2h[1]), .r_color(rcol[1]),
        .vga_x(vx[1]), .vga_y(vy[1]), .vga_color(vc[1]), .vga_plot(vplot[1]),
        .vga_ready(vga_ready), .busy(busy[1]),
`ifdef FRAME_OVERRUN_CNT_EN
        .overrun_cnt(ovr[1]),
`endif
        .frame_done(fdone[1])
    );

    function automatic logic [2:0] col(input logic [7:0] x, input logic [7:0] y);
        return x[2:0] ^ y[3:1] ^ {x[5], y[0], x[7]};
    endfunction

    // Model renderers: 1-cycle loads only on r_ld; 3-cycle holds when the sink stalls.
    logic [2:0] c1;
    logic [2:0] c3 [3];
    always @(posedge clk) if (rld[0]) c1 <= col(rx[0], ry[0]);
    always @(posedge clk) begin
        if (!(vplot[1] && !vga_ready)) begin
            c3[2] <= c3[1];
            c3[1] <= c3[0];
        end
        if (rld[1]) c3[0] <= col(rx[1], ry[1]);
    end
    assign rcol[0] = c1;
    assign rcol[1] = c3[2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Pixel scoreboard: every transfer must be the next raster coordinate.
    logic [7:0] ex [2], ey [2];
    int cnt [2], first [2], rec_first [2], rec_cnt [2], done_cyc [2], ndone [2];
    initial for (int k = 0; k < 2; k++) begin
        ex[k] = 0; ey[k] = 0; cnt[k] = 0; first[k] = 0; rec_first[k] = 0;
        rec_cnt[k] = 0; done_cyc[k] = 0; ndone[k] = 0;
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                cnt[k] = 0; ex[k] = 0; ey[k] = 0;
            end else begin
                if (vplot[k] && vga_ready) begin
                    chk(k == 0 ? "plot_lat1" : "plot_lat3", 64'({vx[k], vy[k], vc[k]}),
                        64'({ex[k], ey[k], col(ex[k], ey[k])}));
                    if (cnt[k] == 0) first[k] = cyc;
                    cnt[k]++;
                    if (ex[k] == 8'd159) begin
                        ex[k] = 0;
                        ey[k] = (ey[k] == 8'd119) ? 8'd0 : ey[k] + 8'd1;
                    end else begin
                        ex[k] = ex[k] + 8'd1;
                    end
                end
                if (fdone[k]) begin
                    done_cyc[k] = cyc; rec_first[k] = first[k]; rec_cnt[k] = cnt[k];
                    cnt[k] = 0; ex[k] = 0; ey[k] = 0; ndone[k]++;
                end
            end
        end
    end

    typedef struct {
        bit         tick;
        bit         stall;
        int         nticks;
        logic [3:0] gs;
        logic [7:0] dy, o1x, o1h, o2x, o2h;
        int         first1, first3, done1, done3;
    } row_t;
    row_t tbl [3];

    function automatic logic [63:0] snap_of(input int r);
        return 64'({tbl[r].gs, tbl[r].dy, tbl[r].o1x, tbl[r].o1h, tbl[r].o2x, tbl[r].o2h});
    endfunction

    task automatic set_live(input int r);
        game_state = tbl[r].gs; dino_y = tbl[r].dy; obs1_x = tbl[r].o1x;
        obs1_h = tbl[r].o1h; obs2_x = tbl[r].o2x; obs2_h = tbl[r].o2h;
    endtask

    task automatic pulse_tick(output int t);
        @(posedge clk); #1 frame_tick = 1'b1; t = cyc;
        @(posedge clk); #1 frame_tick = 1'b0;
    endtask

    task automatic wait_plot(input logic [7:0] x, input logic [7:0] y, input string nm);
        int g = 0;
        do begin @(negedge clk); g++; end
        while (!(vplot[0] && vx[0] == x && vy[0] == y) && g < LIM);
        chk(nm, 64'(g >= LIM), 64'(0));
    endtask

    task automatic check_zero(input int k);
        chk("zero_ctrl", 64'({busy[k], rld[k], fdone[k], vplot[k]}), 64'(0));
        chk("zero_rxy", 64'({rx[k], ry[k]}), 64'(0));
        chk("zero_vga", 64'({vx[k], vy[k], vc[k]}), 64'(0));
        chk("zero_snap", 64'({sgs[k], sdy[k], so1x[k], so1h[k], so2x[k], so2h[k]}), 64'(0));
    endtask

    initial begin
        int t0, tmp, g;
        int t [2];
        tbl[0] = '{1, 0, 0, 4'd2, 8'd40, 8'd100, 8'd20, 8'd150, 8'd30, 4, 6, NPIX+4, NPIX+6};
        tbl[1] = '{1, 1, 3, 4'd1, 8'd60, 8'd90, 8'd25, 8'd140, 8'd12, 4, 6, NPIX+9, NPIX+11};
        tbl[2] = '{0, 0, 0, 4'd3, 8'd75, 8'd10, 8'd8, 8'd200, 8'd44, 4, 6, NPIX+4, NPIX+6};

        set_live(0);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_zero(0); check_zero(1);
        @(posedge clk); #1 reset = 1'b0;

        for (int r = 0; r < 3; r++) begin
            if (tbl[r].tick) begin
                set_live(r);
                pulse_tick(t0);
                t[0] = t0; t[1] = t0;
            end else begin
                t[0] = done_cyc[0]; t[1] = done_cyc[1];
            end

            if (tbl[r].stall) begin
                wait_plot(8'd9, 8'd3, "stall_wait");
                @(posedge clk); #1 vga_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("stall_rld", 64'({rld[0], rld[1]}), 64'(0));
                    chk("stall_hold", 64'({vplot[0], vx[0], vy[0], vc[0]}),
                        64'({1'b1, 8'd10, 8'd3, col(8'd10, 8'd3)}));
                end
                @(posedge clk); #1 vga_ready = 1'b1;
            end

            // Live inputs switch mid-scan to the next frame's values.
            wait_plot(8'd30, 8'd8, "mid_wait");
            set_live((r + 1) % 3);
            for (int i = 0; i < tbl[r].nticks; i++) begin
                pulse_tick(tmp);
                repeat (3) @(posedge clk);
            end
            repeat (20) @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk("snap_hold", 64'({sgs[k], sdy[k], so1x[k], so1h[k], so2x[k], so2h[k]}),
                    snap_of(r));
                chk("busy_mid", 64'(busy[k]), 64'(1));
            end

            g = 0;
            while ((ndone[0] < r + 1 || ndone[1] < r + 1) && g < LIM) begin
                @(negedge clk);
                g++;
            end
            chk("done_timeout", 64'(g >= LIM), 64'(0));
            chk("first_lat1", 64'(rec_first[0] - t[0]), 64'(tbl[r].first1));
            chk("first_lat3", 64'(rec_first[1] - t[1]), 64'(tbl[r].first3));
            chk("done_lat1", 64'(done_cyc[0] - t[0]), 64'(tbl[r].done1));
            chk("done_lat3", 64'(done_cyc[1] - t[1]), 64'(tbl[r].done3));
            chk("count_lat1", 64'(rec_cnt[0]), 64'(NPIX));
            chk("count_lat3", 64'(rec_cnt[1]), 64'(NPIX));
            if (r < 2) chk("busy_after", 64'(busy[0]), 64'(!tbl[r+1].tick));
`ifdef FRAME_OVERRUN_CNT_EN
            if (r == 1) begin
                chk("overrun1", 64'(ovr[0]), 64'(2));
                chk("overrun3", 64'(ovr[1]), 64'(2));
            end
`endif
        end

        // Abandon a frame part-way, then confirm a clean restart at (0,0).
        pulse_tick(t0);
        wait_plot(8'd80, 8'd60, "rst_wait");
        @(posedge clk); #1 reset = 1'b1;
        #1 check_zero(0); check_zero(1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        pulse_tick(t0);
        wait_plot(8'd0, 8'd0, "rst_first_wait");
        chk("rst_first_lat1", 64'(cyc - t0), 64'(4));
        repeat (4) @(negedge clk);
        chk("rst_first_lat3", 64'(first[1] - t0), 64'(6));
        chk("rst_count3", 64'(cnt[1] > 0), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_render_sequencer.md
Name: frame_render_sequencer

Overview:
- Sequences the per-pixel game renderer once per frame: snapshots game state on the frame tick, scans every (x,y) coordinate, pulses the renderer load strobe, and forwards each returned color to the VGA framebuffer write port.
- Sits between the game-logic FSM / frame-tick generator and the pixel renderer + VGA adapter.
- Owns the `ldClk`-equivalent load enable, so the renderer runs on the system clock with no derived clocks.

Parameters:
- SCREEN_W, 160, horizontal pixel count; x scans 0..SCREEN_W-1.
- SCREEN_H, 120, vertical pixel count; y scans 0..SCREEN_H-1.
- RENDER_LAT, 1, cycles from r_ld sampled to r_color valid; range 1..4.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle frame-start pulse.
- game_state  in  4  live game state.
- dino_y, obs1_x, obs1_h, obs2_x, obs2_h  in  8 each  live object state.
- r_x, r_y  out  8 each  coordinate presented to the renderer.
- r_ld  out  1  renderer load enable; the renderer updates only when this is high.
- r_game_state  out  4  snapshot value, stable for the whole frame.
- r_dino_y, r_obs1_x, r_obs1_h, r_obs2_x, r_obs2_h  out  8 each  snapshot values, stable for the whole frame.
- r_color  in  3  renderer output color.
- vga_x, vga_y  out  8 each  framebuffer write coordinate.
- vga_color  out  3  framebuffer write color.
- vga_plot  out  1  write valid.
- vga_ready  in  1  framebuffer accept.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
- Reset values: all outputs 0; state IDLE; pending flag 0.
- States:
  - IDLE: frame_tick → SNAP.
  - SNAP: single cycle; latch all r_* snapshot registers from the live inputs; x=y=0 → SCAN.
  - SCAN: issue one coordinate per unstalled cycle.
  - DRAIN: wait for in-flight pixels to be accepted.
  - DONE: single cycle; pulse frame_done → IDLE, or → SNAP if a tick is pending.
- Snapshot registers change only in SNAP. Live inputs changing mid-frame have no effect.
- Issue (SCAN): r_ld=1 with r_x/r_y = current x,y.
  - x increments first; at SCREEN_W-1 it wraps to 0 and y increments.
  - After issuing (SCREEN_W-1, SCREEN_H-1) → DRAIN.
- Tag pipeline: a RENDER_LAT-deep shift register of {valid, x, y} tracks issued coordinates. When a valid tag emerges, {tag x, tag y, r_color} is registered into vga_x/vga_y/vga_color with vga_plot=1.
- Handshake:
  - A transfer occurs on any cycle with vga_plot && vga_ready.
  - Stall = vga_plot && !vga_ready. During a stall: r_ld=0, x/y counters frozen, tag pipeline frozen, and vga_* held stable.
  - vga_plot never drops without acceptance.
  - The renderer must hold its output while r_ld=0.
- Latency, with vga_ready tied high and frame_tick sampled at T:
  - SNAP at T+1; SCAN from T+2.
  - (0,0) issued at T+2, plotted at T+3+RENDER_LAT.
  - Pixel n plotted at T+3+RENDER_LAT+n.
  - frame_done at T+3+RENDER_LAT+SCREEN_W*SCREEN_H.
- busy is high in SNAP, SCAN, DRAIN and DONE; low only in IDLE.
- DRAIN → DONE once the tag pipeline is empty and the final vga transfer has completed.
- frame_tick outside IDLE: sets pending (saturates at 1; extra ticks are lost). DONE consumes pending and goes directly to SNAP.
- frame_tick coinciding with DONE: treated as pending.
- Reset mid-frame: immediate return to IDLE; vga_plot drops asynchronously; the partial frame is abandoned.
- Widths: x/y counters are 8-bit. Comparisons against SCREEN_W-1 and SCREEN_H-1 are unsigned. No arithmetic wraps beyond 8 bits for legal parameters (≤255).

Optional Feature:
- Macro: FRAME_OVERRUN_CNT_EN.
- With the macro: adds output overrun_cnt [15:0].
  - Increments (saturating at 16'hFFFF) on each frame_tick that arrives while pending is already 1, i.e. on each lost tick.
  - Cleared by reset only.
- Without the macro: port and counter are absent; lost ticks are silently dropped.

Decomposition:
- Shared package/constants header (existing DinoGame constants):
  - SCREEN_W, SCREEN_H.
  - ubyte width macro.
  - 3-bit color type.
  - 4-bit game-state encoding.
  - Sequencer state encoding: IDLE, SNAP, SCAN, DRAIN, DONE.
- One natural sub-module, render_tag_pipe: a parameterised RENDER_LAT-deep {valid, x, y} shift register with freeze enable.

Test Plan:
- Full frame, vga_ready=1, RENDER_LAT=1, tick at T:
  - first plot (0,0) at T+4;
  - (159,0) then (0,1) on consecutive cycles;
  - frame_done at T+19204;
  - exactly 19200 plots, each coordinate once.
- Backpressure: deassert vga_ready for 5 cycles at pixel (10,3) → vga_x/vga_y/vga_color held constant; r_ld=0 throughout; no pixel lost or duplicated; frame_done delayed by exactly 5 cycles.
- Snapshot isolation: change dino_y 40→60 mid-SCAN → r_dino_y stays 40 until the next SNAP.
- Ticks during a frame: three frame_ticks during SCAN → exactly one follow-on frame starts directly after DONE (SNAP the next cycle); with FRAME_OVERRUN_CNT_EN, overrun_cnt=2.
- Reset mid-frame at pixel (80,60) → all outputs 0 and state IDLE; the next tick starts a fresh frame at (0,0).
- RENDER_LAT=3 with a model renderer of 3-cycle latency → colors match the coordinate model at every plot; frame_done at T+19206.
